// File: rtl/frame_sched_if.sv
// Handshake bundle between the frame scheduler and the object-update stages.
interface frame_sched_if #(
    parameter int FRAME_CNT_W = 16
);
    logic                   frame_tick_i;
    logic                   pause_i;
    logic                   me_start_o;
    logic                   me_done_i;
    logic                   bullet_start_o;
    logic                   bullet_done_i;
    logic                   enemy_start_o;
    logic                   enemy_done_i;
    logic                   coll_start_o;
    logic                   coll_done_i;
    logic                   busy_o;
    logic [2:0]             stage_o;
    logic [FRAME_CNT_W-1:0] frame_cnt_o;
    logic [7:0]             overrun_cnt_o;
    logic                   timeout_o;

    modport master (
        input  frame_tick_i, pause_i,
        input  me_done_i, bullet_done_i, enemy_done_i, coll_done_i,
        output me_start_o, bullet_start_o, enemy_start_o, coll_start_o,
        output busy_o, stage_o, frame_cnt_o, overrun_cnt_o, timeout_o
    );

    modport slave (
        output frame_tick_i, pause_i,
        output me_done_i, bullet_done_i, enemy_done_i, coll_done_i,
        input  me_start_o, bullet_start_o, enemy_start_o, coll_start_o,
        input  busy_o, stage_o, frame_cnt_o, overrun_cnt_o, timeout_o
    );
endinterface

// File: rtl/frame_sched.sv
// Per-frame game-logic scheduler: on each frame tick runs player, bullet, enemy
// and collision updates in order, with per-stage timeout and frame/overrun counters.
//
// state  | meaning
// IDLE   | waiting for an unpaused frame tick
// ME     | player-plane update running
// BULLET | bullet update running
// ENEMY  | enemy update running
// COLL   | collision pass running
// DONE   | frame finished; one cycle, frame counter bumps on exit
module frame_sched #(
    parameter int TIMEOUT     = 4096,
    parameter int FRAME_CNT_W = 16
) (
    input  logic          clk_run,
    input  logic          rst_n,
    frame_sched_if.master bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ME     = 3'd1,
        S_BULLET = 3'd2,
        S_ENEMY  = 3'd3,
        S_COLL   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_nx;
    logic [CNT_W-1:0]       cnt_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic [7:0]             overrun_r;
    logic                   timeout_r;
    logic                   in_stage;
    logic                   own_done;
    logic                   stage_to;
    logic                   cnt_zero;

    assign in_stage = (state_r == S_ME) || (state_r == S_BULLET) ||
                      (state_r == S_ENEMY) || (state_r == S_COLL);
    assign cnt_zero = (cnt_r == '0);

    always_comb begin
        own_done = 1'b0;
        case (state_r)
            S_ME:     own_done = bus.me_done_i;
            S_BULLET: own_done = bus.bullet_done_i;
            S_ENEMY:  own_done = bus.enemy_done_i;
            S_COLL:   own_done = bus.coll_done_i;
            default:  own_done = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state_r;
        stage_to = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.frame_tick_i && !bus.pause_i) state_nx = S_ME;
            end
            S_ME, S_BULLET, S_ENEMY, S_COLL: begin
                // done is ignored on the edge that closes the start cycle;
                // a done on the timeout edge still counts as a clean finish
                if (!cnt_zero && own_done) begin
                    state_nx = state_t'(state_r + 3'd1);
                end else if (cnt_r == CNT_LAST) begin
                    state_nx = state_t'(state_r + 3'd1);
                    stage_to = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            frame_cnt_r <= '0;
            overrun_r   <= '0;
            timeout_r   <= 1'b0;
        end else begin
            state_r   <= state_nx;
            timeout_r <= stage_to;
            if ((state_nx != state_r) || !in_stage) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r == S_DONE) begin
                frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
            end
            if (bus.frame_tick_i && (state_r != S_IDLE) && (overrun_r != 8'hFF)) begin
                overrun_r <= overrun_r + 8'd1;
            end
        end
    end

    assign bus.me_start_o     = (state_r == S_ME)     && cnt_zero;
    assign bus.bullet_start_o = (state_r == S_BULLET) && cnt_zero;
    assign bus.enemy_start_o  = (state_r == S_ENEMY)  && cnt_zero;
    assign bus.coll_start_o   = (state_r == S_COLL)   && cnt_zero;
    assign bus.busy_o         = (state_r != S_IDLE);
    assign bus.stage_o        = state_r;
    assign bus.frame_cnt_o    = frame_cnt_r;
    assign bus.overrun_cnt_o  = overrun_r;
    assign bus.timeout_o      = timeout_r;
endmodule
